// File: rtl/pll_freq_monitor_if.sv
// Control, PLL toggle and status bundle of the PLL frequency/lock monitor.
// The monitor uses the slave view; housekeeping logic or a bench uses the master view.
interface pll_freq_monitor_if #(
    parameter int unsigned WIN_W = 16,
    parameter int unsigned CNT_W = 16
);
    logic             enable;
    logic [WIN_W-1:0] window_len;
    logic [CNT_W-1:0] exp_min;
    logic [CNT_W-1:0] exp_max;
    logic             pll_toggle;
    logic             clear_sticky;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             in_range;
    logic             locked;
    logic             lock_lost;
    logic             overflow;

    modport master (
        output enable, window_len, exp_min, exp_max, pll_toggle, clear_sticky,
        input  count_out, count_valid, in_range, locked, lock_lost, overflow
    );

    modport slave (
        input  enable, window_len, exp_min, exp_max, pll_toggle, clear_sticky,
        output count_out, count_valid, in_range, locked, lock_lost, overflow
    );
endinterface

// File: rtl/pll_freq_monitor.sv
// Counts PLL toggle edges over a window of reference clocks, checks the count against a
// min/max range and derives a lock status from consecutive passing windows.
module pll_freq_monitor #(
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LOCK_N = 4
) (
    input  logic              clock,
    input  logic              reset,
    pll_freq_monitor_if.slave mon
);
    localparam int unsigned       PASS_W  = 4;
    localparam logic [PASS_W-1:0] PassMax = PASS_W'(LOCK_N);
    localparam logic [CNT_W-1:0]  CntMax  = '1;

    typedef enum logic [1:0] {StIdle, StFlush, StMeasure, StReport} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [1:0]         r_flush_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_min;
    logic [CNT_W-1:0]   r_max;
    logic [PASS_W-1:0]  r_pass;
    logic [CNT_W-1:0]   r_count_out;
    logic               r_count_valid;
    logic               r_in_range;
    logic               r_overflow;
    logic               r_locked;
    logic               r_lock_lost;

    logic               w_edge;
    logic               w_start_ok;
    logic               w_win_start;
    logic               w_in_range;
    logic               w_report;
    logic               w_pass_full;
    logic               w_lock_drop;

    assign w_edge      = r_sync2 ^ r_sync3;
    assign w_start_ok  = mon.enable && (mon.window_len != '0);
    assign w_win_start = (w_state_next == StMeasure) && (r_state != StMeasure);
    assign w_in_range  = (r_edge_cnt >= r_min) && (r_edge_cnt <= r_max) && !r_ovf;
    assign w_report    = (r_state == StReport) && mon.enable;
    assign w_pass_full = (r_pass == PassMax);
    // Only a failing window can drop lock while enabled; disable clears lock silently.
    assign w_lock_drop = mon.enable && r_locked && !w_pass_full;

    always_comb begin
        w_state_next = r_state;
        if (!mon.enable) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_start_ok) w_state_next = StFlush;
                end
                StFlush: begin
                    if (r_flush_cnt == 2'd2) w_state_next = w_start_ok ? StMeasure : StIdle;
                end
                StMeasure: begin
                    if (r_win_cnt == '0) w_state_next = StReport;
                end
                StReport: begin
                    w_state_next = w_start_ok ? StMeasure : StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StIdle;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync3       <= 1'b0;
            r_flush_cnt   <= 2'd0;
            r_win_cnt     <= '0;
            r_edge_cnt    <= '0;
            r_ovf         <= 1'b0;
            r_min         <= '0;
            r_max         <= '0;
            r_pass        <= '0;
            r_count_out   <= '0;
            r_count_valid <= 1'b0;
            r_in_range    <= 1'b0;
            r_overflow    <= 1'b0;
            r_locked      <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sync1     <= mon.pll_toggle;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_flush_cnt <= (r_state == StFlush) ? r_flush_cnt + 2'd1 : 2'd0;

            if (w_win_start) begin
                r_win_cnt  <= mon.window_len - 1'b1;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
                r_min      <= mon.exp_min;
                r_max      <= mon.exp_max;
            end else if (r_state == StMeasure) begin
                r_win_cnt <= r_win_cnt - 1'b1;
                if (w_edge) begin
                    if (r_edge_cnt == CntMax) r_ovf <= 1'b1;
                    else                      r_edge_cnt <= r_edge_cnt + 1'b1;
                end
            end else if (r_state == StIdle) begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
            end

            r_count_valid <= w_report;
            if (w_report) begin
                r_count_out <= r_edge_cnt;
                r_in_range  <= w_in_range;
                r_overflow  <= r_ovf;
                if (!w_in_range)      r_pass <= '0;
                else if (!w_pass_full) r_pass <= r_pass + 1'b1;
            end else if (!mon.enable) begin
                r_pass <= '0;
            end

            // Lock trails the pass counter by one cycle.
            r_locked <= mon.enable && w_pass_full;

            if (w_lock_drop)           r_lock_lost <= 1'b1;
            else if (mon.clear_sticky) r_lock_lost <= 1'b0;
        end
    end

    assign mon.count_out   = r_count_out;
    assign mon.count_valid = r_count_valid;
    assign mon.in_range    = r_in_range;
    assign mon.overflow    = r_overflow;
    assign mon.locked      = r_locked;
    assign mon.lock_lost   = r_lock_lost;
endmodule

// File: tb/tb_pll_freq_monitor.sv
// Bench for pll_freq_monitor: a 16-bit and a 4-bit counter instance share stimulus and are
// checked every cycle against a window/transition-counting reference model.
module tb_pll_freq_monitor;
    localparam int unsigned WIN_W   = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_W_S = 4;
    localparam int unsigned LOCK_N  = 4;
    localparam int          MAX_CYC = 65536;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en    = 1'b0;
    logic [15:0] wl    = '0;
    logic [15:0] emin  = '0;
    logic [15:0] emax  = '0;
    logic        pin   = 1'b0;
    logic        clr   = 1'b0;
    int unsigned half  = 4;  // toggle half period in clocks; 0 gives random toggling

    always #5 clock = ~clock;

    pll_freq_monitor_if #(.WIN_W(WIN_W), .CNT_W(CNT_W))   bus_a ();
    pll_freq_monitor_if #(.WIN_W(WIN_W), .CNT_W(CNT_W_S)) bus_b ();

    assign bus_a.enable       = en;
    assign bus_a.window_len   = wl;
    assign bus_a.exp_min      = emin;
    assign bus_a.exp_max      = emax;
    assign bus_a.pll_toggle   = pin;
    assign bus_a.clear_sticky = clr;
    assign bus_b.enable       = en;
    assign bus_b.window_len   = wl;
    assign bus_b.exp_min      = emin[CNT_W_S-1:0];
    assign bus_b.exp_max      = emax[CNT_W_S-1:0];
    assign bus_b.pll_toggle   = pin;
    assign bus_b.clear_sticky = clr;

    pll_freq_monitor #(.WIN_W(WIN_W), .CNT_W(CNT_W), .LOCK_N(LOCK_N)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .mon   (bus_a.slave)
    );

    pll_freq_monitor #(.WIN_W(WIN_W), .CNT_W(CNT_W_S), .LOCK_N(LOCK_N)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .mon   (bus_b.slave)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: pin level recorded per clock; a window's count is the number of
    // pin transitions it saw, delayed by the 3-clock synchronizer latency.
    bit          hist [MAX_CYC];
    bit          m_ok = 0;
    bit          m_run, m_in_win, m_cv;
    int          m_start_due, m_v_due, m_win_start, m_win;
    int unsigned m_min [2];
    int unsigned m_max [2];
    int unsigned m_cnt [2];
    int unsigned m_pass [2];
    bit          m_inr [2];
    bit          m_ovf [2];
    bit          m_locked [2];
    bit          m_lost [2];

    task automatic model_step();
        int unsigned raw;
        int unsigned lim;
        bit          drop;
        if (cyc < MAX_CYC) hist[cyc] = pin;
        if (reset) begin
            m_ok = 1; m_run = 0; m_in_win = 0; m_cv = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_pass[i] = 0; m_inr[i] = 0; m_ovf[i] = 0;
                m_locked[i] = 0; m_lost[i] = 0;
            end
        end else if (m_ok) begin
            m_cv = 0;
            if (!en) begin
                m_run = 0; m_in_win = 0;
                for (int i = 0; i < 2; i++) begin
                    m_pass[i] = 0; m_locked[i] = 0;
                    if (clr) m_lost[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    drop = m_locked[i] && (m_pass[i] != LOCK_N);
                    m_locked[i] = (m_pass[i] == LOCK_N);
                    if (drop)     m_lost[i] = 1;
                    else if (clr) m_lost[i] = 0;
                end
                if (m_run && m_in_win && cyc == m_v_due) begin
                    raw = 0;
                    for (int k = m_win_start - 1; k <= m_win_start + m_win - 2; k++)
                        if (hist[k] != hist[k-1]) raw++;
                    m_cv = 1;
                    for (int i = 0; i < 2; i++) begin
                        lim = (i == 0) ? 32'hFFFF : 32'hF;
                        m_ovf[i] = (raw > lim);
                        m_cnt[i] = m_ovf[i] ? lim : raw;
                        m_inr[i] = (m_cnt[i] >= m_min[i]) && (m_cnt[i] <= m_max[i]) && !m_ovf[i];
                        if (!m_inr[i])              m_pass[i] = 0;
                        else if (m_pass[i] < LOCK_N) m_pass[i]++;
                    end
                    m_in_win = 0;
                    m_start_due = cyc;
                end else if (!m_run && wl != 0) begin
                    m_run = 1; m_in_win = 0; m_start_due = cyc + 3;
                end
                if (m_run && !m_in_win && cyc == m_start_due) begin
                    if (wl == 0) begin
                        m_run = 0;
                    end else begin
                        m_in_win = 1; m_win_start = cyc; m_win = int'(wl);
                        m_v_due = cyc + int'(wl) + 1;
                        m_min[0] = int'(emin); m_max[0] = int'(emax);
                        m_min[1] = int'(emin) & 15; m_max[1] = int'(emax) & 15;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic check_outputs();
        if (!m_ok) return;
        check_eq("a_count_valid", 32'(bus_a.count_valid), 32'(m_cv));
        check_eq("a_count_out",   32'(bus_a.count_out),   m_cnt[0]);
        check_eq("a_in_range",    32'(bus_a.in_range),    32'(m_inr[0]));
        check_eq("a_overflow",    32'(bus_a.overflow),    32'(m_ovf[0]));
        check_eq("a_locked",      32'(bus_a.locked),      32'(m_locked[0]));
        check_eq("a_lock_lost",   32'(bus_a.lock_lost),   32'(m_lost[0]));
        check_eq("b_count_valid", 32'(bus_b.count_valid), 32'(m_cv));
        check_eq("b_count_out",   32'(bus_b.count_out),   m_cnt[1]);
        check_eq("b_in_range",    32'(bus_b.in_range),    32'(m_inr[1]));
        check_eq("b_overflow",    32'(bus_b.overflow),    32'(m_ovf[1]));
        check_eq("b_locked",      32'(bus_b.locked),      32'(m_locked[1]));
        check_eq("b_lock_lost",   32'(bus_b.lock_lost),   32'(m_lost[1]));
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        check_outputs();
    end

    initial begin
        int unsigned c = 0;
        forever begin
            @(negedge clock);
            if (half == 0) begin
                if ($urandom_range(0, 2) == 0) pin = ~pin;
            end else begin
                c++;
                if (c >= half) begin
                    c = 0;
                    pin = ~pin;
                end
            end
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_cv(input int unsigned budget, input bit want_fail);
        int unsigned i     = 0;
        bit          found = 0;
        while (!found && i < budget) begin
            @(negedge clock);
            i++;
            if (bus_a.count_valid && (!want_fail || !bus_a.in_range)) found = 1;
        end
        if (!found) check_eq(want_fail ? "wait_fail_timeout" : "wait_cv_timeout", 0, 1);
    endtask

    task automatic set_window(input logic [15:0] w, input logic [15:0] lo, input logic [15:0] hi);
        en = 1'b0;
        cycles(2);
        wl = w; emin = lo; emax = hi;
        en = 1'b1;
    endtask

    initial begin
        int unsigned n;
        cycles(4);
        reset = 1'b0;
        check_eq("rst_count_out", 32'(bus_a.count_out), 0);
        check_eq("rst_locked", 32'(bus_a.locked), 0);

        // Nominal: 25 edges per 100-cycle window, lock the cycle after the 4th report.
        wl = 100; emin = 24; emax = 26; en = 1'b1;
        for (int w = 1; w <= 5; w++) begin
            wait_cv(200, 0);
            check_eq("nom_count", 32'(bus_a.count_out), 25);
            check_eq("nom_in_range", 32'(bus_a.in_range), 1);
            if (w == 4) begin
                check_eq("nom_locked_before", 32'(bus_a.locked), 0);
                cycles(1);
                check_eq("nom_locked_after", 32'(bus_a.locked), 1);
            end
        end

        // Out of range.
        set_window(100, 24, 20);
        repeat (4) begin
            wait_cv(200, 0);
            check_eq("oor_count", 32'(bus_a.count_out), 25);
            check_eq("oor_in_range", 32'(bus_a.in_range), 0);
            check_eq("oor_locked", 32'(bus_a.locked), 0);
            check_eq("oor_lost", 32'(bus_a.lock_lost), 0);
        end

        // Lock loss, sticky clear, then clear colliding with a new loss.
        set_window(100, 24, 26);
        repeat (6) wait_cv(200, 0);
        check_eq("ll_locked", 32'(bus_a.locked), 1);
        half = 2;
        wait_cv(400, 1);
        cycles(1);
        check_eq("ll_locked_drop", 32'(bus_a.locked), 0);
        check_eq("ll_lost_set", 32'(bus_a.lock_lost), 1);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check_eq("ll_lost_clear", 32'(bus_a.lock_lost), 0);
        half = 4;
        repeat (7) wait_cv(200, 0);
        check_eq("ll_relocked", 32'(bus_a.locked), 1);
        half = 2;
        wait_cv(400, 1);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check_eq("ll_set_wins", 32'(bus_a.lock_lost), 1);

        // Saturation of the 4-bit instance.
        half = 1;
        set_window(40, 0, 15);
        repeat (3) wait_cv(100, 0);
        check_eq("sat_count_b", 32'(bus_b.count_out), 15);
        check_eq("sat_ovf_b", 32'(bus_b.overflow), 1);
        check_eq("sat_inr_b", 32'(bus_b.in_range), 0);
        check_eq("sat_count_a", 32'(bus_a.count_out), 40);

        // Disable mid-window.
        half = 4;
        set_window(100, 24, 26);
        repeat (6) wait_cv(200, 0);
        cycles(50);
        en = 1'b0;
        cycles(1);
        check_eq("dis_locked", 32'(bus_a.locked), 0);
        n = 0;
        repeat (150) begin
            @(negedge clock);
            if (bus_a.count_valid) n++;
        end
        check_eq("dis_no_cv", n, 0);
        check_eq("dis_count_hold", 32'(bus_a.count_out), 25);

        // Zero window length.
        set_window(0, 0, 100);
        n = 0;
        repeat (500) begin
            @(negedge clock);
            if (bus_a.count_valid) n++;
        end
        check_eq("zero_win_cv", n, 0);

        // Reset mid-measure with lock held, then re-lock timing.
        set_window(100, 24, 26);
        repeat (6) wait_cv(200, 0);
        cycles(30);
        check_eq("rm_locked_pre", 32'(bus_a.locked), 1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check_eq("rm_locked", 32'(bus_a.locked), 0);
        check_eq("rm_count", 32'(bus_a.count_out), 0);
        check_eq("rm_in_range", 32'(bus_a.in_range), 0);
        n = 0;
        while (!bus_a.locked && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check_eq("rm_relock_cycles", n, 1 + 3 + LOCK_N * (100 + 1) + 1);

        // Randomized toggles, limits, enable drops and sticky clears.
        half = 0;
        for (int t = 0; t < 8; t++) begin
            set_window(16'($urandom_range(1, 60)), 16'($urandom_range(0, 25)),
                       16'($urandom_range(0, 30)));
            repeat ($urandom_range(150, 400)) begin
                @(negedge clock);
                clr = ($urandom_range(0, 49) == 0);
                en  = ($urandom_range(0, 299) != 0);
                if ($urandom_range(0, 199) == 0) begin
                    wl   = 16'($urandom_range(0, 60));
                    emin = 16'($urandom_range(0, 25));
                    emax = 16'($urandom_range(0, 30));
                end
            end
            clr = 1'b0;
        end
        en = 1'b0;
        cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pll_freq_monitor.md
Name: pll_freq_monitor

Overview:
- Synthesizable frequency and lock monitor that sits directly downstream of the digital PLL in the management clocking block.
- Consumes a divided toggle from the PLL output domain and counts its edges over a programmable window of the reference clock.
- Checks each count against a programmed min/max range and reports measured count, in-range status and lock status to the housekeeping registers.
- Firmware uses it to confirm the PLL trim before switching the core clock to the PLL.

Parameters:
- WIN_W, 16: width of window-length counter (reference cycles).
- CNT_W, 16: width of edge counter and limit registers.
- LOCK_N, 4: consecutive in-range windows required to assert locked (1..15).

Ports:
- clock  input  1  reference clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run measurement when high; low returns to IDLE next cycle.
- window_len  input  WIN_W  window length in clock cycles; sampled at window start.
- exp_min  input  CNT_W  minimum allowed edge count (inclusive); sampled at window start.
- exp_max  input  CNT_W  maximum allowed edge count (inclusive); sampled at window start.
- pll_toggle  input  1  asynchronous PLL-divided toggle; every transition counts as one edge.
- clear_sticky  input  1  single-cycle pulse that clears lock_lost.
- count_out  output  CNT_W  edge count of the last completed window.
- count_valid  output  1  one-cycle pulse when count_out updates.
- in_range  output  1  result of the last completed window.
- locked  output  1  lock status.
- lock_lost  output  1  sticky flag: locked fell while enable stayed high.
- overflow  output  1  last completed window saturated the edge counter.

Behaviour:
- Reset values: all outputs 0; state IDLE; synchronizer flops 0; consecutive-pass counter 0.
- Synchronizer: pll_toggle passes through a 2-flop synchronizer, then a third flop for edge detection.
  - edge = sync2 XOR sync3.
  - Latency from pin transition to edge pulse: 3 clocks.
- States:
  - IDLE: counters cleared.
    - If enable=1 and window_len!=0, go to FLUSH.
    - window_len==0 keeps the block in IDLE and produces no count_valid.
  - FLUSH: lasts 3 cycles so that stale synchronizer contents are ignored; edges are not counted. Then go to MEASURE.
  - MEASURE, on entry:
    - Latch window_len, exp_min and exp_max.
    - Load the window counter with window_len-1.
    - Clear the edge counter.
  - MEASURE, each cycle:
    - Add edge to the edge counter. The counter saturates at all-ones and sets the internal ovf bit.
    - Decrement the window counter.
  - MEASURE, in the cycle the window counter is 0: the edge for that cycle is included, then go to REPORT. A window therefore covers exactly window_len cycles.
  - REPORT (1 cycle), registered outputs visible the cycle after REPORT:
    - count_out = final count; count_valid = 1.
    - overflow = ovf.
    - in_range = (count >= exp_min) AND (count <= exp_max) AND NOT ovf.
    - exp_min > exp_max makes in_range always 0.
  - REPORT, pass counter:
    - in_range=1: pass counter increments, saturating at LOCK_N.
    - in_range=0: pass counter clears.
  - REPORT, lock:
    - locked = 1 once the pass counter reaches LOCK_N.
    - locked = 0 on the first failing window.
    - If locked was 1 and falls here, lock_lost is set.
  - REPORT, exit: go directly to MEASURE (back-to-back windows, no FLUSH) if enable=1, else to IDLE.
- Edges during REPORT are not counted. The gap of 1 cycle per window is accepted as measurement error.
- Deasserting enable in any state:
  - Go to IDLE next cycle and abort any partial window; no count_valid.
  - locked and the pass counter clear.
  - count_out, in_range and overflow hold their last values.
  - lock_lost is not set by disable.
- clear_sticky:
  - Clears lock_lost next cycle.
  - If clear_sticky and a lock-loss occur in the same cycle, set wins.
- Input changes to window_len, exp_min and exp_max mid-window take effect at the next window start only.
- reset mid-operation: next cycle all state returns to reset values, regardless of enable.

Test Plan:
- Nominal lock: pll_toggle period 8 clocks (1 edge per 4 clocks), window_len=100, exp_min=24, exp_max=26, LOCK_N=4.
  - Every window gives count_out=25, in_range=1.
  - locked rises in the cycle after the 4th count_valid.
- Out of range: same stimulus with exp_max=20.
  - count_out=25, in_range=0 every window; locked stays 0; lock_lost stays 0.
- Lock loss: lock as in the nominal case, then change the toggle period to 4 clocks (count 50).
  - First failing window: locked→0, lock_lost→1.
  - clear_sticky pulse: lock_lost→0 next cycle.
  - Simultaneous clear_sticky and lock loss: lock_lost=1.
- Saturation: CNT_W=4, toggle every clock, window_len=40.
  - count_out=15, overflow=1, in_range=0 even with exp_max=15.
- Disable and zero window:
  - Drop enable mid-window: no count_valid; locked=0; count_out keeps its previous value.
  - window_len=0 with enable=1: no count_valid for 500 cycles.
- Reset mid-MEASURE: assert reset for 1 cycle with locked=1.
  - All outputs 0 next cycle.
  - Re-lock takes exactly 3 flush cycles plus LOCK_N windows.
